// File: rtl/bitbal_pkg.sv
// Shared definitions for the bit-balancer popcount path: FSM encodings,
// the fixed slice width and width helpers used to size ports.
package bitbal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int SLICE_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic int CNT_W(input int word_w);
    return clog2(word_w + 1);
  endfunction

  // Never returns zero so a single-entry index still gets a real bit.
  function automatic int ID_W(input int nreq);
    return (nreq > 1) ? clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/popcount8.sv
// Combinational ones counter for one 8-bit slice; the shared datapath
// time-multiplexed by popcount_sched.
module popcount8 (
  input  logic [7:0] i_data,
  output logic [3:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < 8; i++) o_count = o_count + {3'b000, i_data[i]};
  end

endmodule

// File: rtl/popcount_sched.sv
// Round-robin scheduler streaming each granted word through one popcount8
// slice per cycle and returning the tagged ones-count.
module popcount_sched
  import bitbal_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WORD_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WORD_W-1:0]     req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_W(NREQ)-1:0]      res_id,
  output logic [CNT_W(WORD_W)-1:0]   res_count,
  output logic                       busy
);

  localparam int NSLICE = WORD_W / SLICE_W;
  localparam int CW     = CNT_W(WORD_W);
  localparam int IW     = ID_W(NREQ);
  localparam int SW     = ID_W(NSLICE);

  state_e              r_state, w_next;
  logic [IW-1:0]       r_last, r_res_id, w_gid;
  logic                w_found, w_hs, w_last_slice, r_res_valid;
  logic [WORD_W-1:0]   r_shift;
  logic [CW-1:0]       r_acc, r_res_count, w_sum;
  logic [SW-1:0]       r_slice;
  logic [3:0]          w_pc;

  popcount8 u_pc (
    .i_data  (r_shift[SLICE_W-1:0]),
    .o_count (w_pc)
  );

  assign w_sum        = r_acc + CW'(w_pc);
  assign w_last_slice = (r_slice == SW'(NSLICE - 1));

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gid   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(r_last) + i) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gid   = IW'(idx);
      end
    end
  end

  assign w_hs      = (r_state == ST_IDLE) && w_found && !reset;
  assign req_ready = w_hs ? (NREQ'(1) << w_gid) : '0;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_count = r_res_count;
  assign busy      = (r_state != ST_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_hs)         w_next = ST_COUNT;
      ST_COUNT: if (w_last_slice) w_next = ST_DONE;
      ST_DONE:  if (res_ready)    w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= IW'(NREQ - 1);
      r_res_id    <= '0;
      r_res_count <= '0;
      r_res_valid <= 1'b0;
      r_slice     <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_last   <= w_gid;
        r_res_id <= w_gid;
        r_slice  <= '0;
      end else if (r_state == ST_COUNT) begin
        r_slice <= r_slice + SW'(1);
        if (w_last_slice) begin
          r_res_count <= w_sum;
          r_res_valid <= 1'b1;
        end
      end else if (r_state == ST_DONE && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  // Datapath registers are fully reloaded on every handshake.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_shift <= req_data[int'(w_gid)*WORD_W +: WORD_W];
      r_acc   <= '0;
    end else if (r_state == ST_COUNT) begin
      r_shift <= r_shift >> SLICE_W;
      r_acc   <= w_sum;
    end
  end

endmodule

// File: tb/tb_popcount_sched.sv
// Directed and randomized bench for popcount_sched against a round-robin
// and ones-count reference model.
module tb_popcount_sched;

  localparam int NREQ   = 4;
  localparam int WORD_W = 32;

  logic                   clk = 1'b0;
  logic                   clk_en = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WORD_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   res_valid;
  logic                   res_ready;
  logic [1:0]             res_id;
  logic [5:0]             res_count;
  logic                   busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_last = NREQ - 1;

  popcount_sched #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_count (res_count),
    .busy      (busy)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int last);
    for (int i = 1; i <= NREQ; i++)
      if (v[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  task automatic await_grant(input string tag, output int gid);
    int c;
    c = 0;
    #1;
    while (req_ready == 0 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_bound"}, c < 20, 1);
    gid = model_grant(req_valid, m_last);
    chk({tag, "_ready"}, req_ready, (gid < 0) ? 0 : (1 << gid));
  endtask

  // Called just after the handshake edge.
  task automatic collect(input string tag, input int id, input logic [31:0] w);
    int lat;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_id"}, res_id, id);
    chk({tag, "_cnt"}, res_count, $countones(w));
  endtask

  task automatic serve(input string tag, input int id, input logic [31:0] w);
    int g;
    req_data[id*WORD_W +: WORD_W] = w;
    req_valid = NREQ'(1) << id;
    res_ready = 1'b1;
    await_grant(tag, g);
    @(posedge clk); #1;
    req_valid = '0;
    m_last = g;
    collect(tag, g, w);
    @(posedge clk); #1;
    chk({tag, "_consumed"}, {res_valid, busy}, 2'b00);
  endtask

  initial begin
    int g, nh, nr, prev;
    int pend[$];
    bit stop, seen0;
    logic [31:0] w0, bw, rw, ww, w3;
    logic [31:0] fw [NREQ];

    // Reset with the clock stopped
    reset = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b0;
    #3;
    chk("rst_valid", res_valid, 0);
    chk("rst_count", res_count, 0);
    chk("rst_id", res_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    w0 = $urandom;
    req_data[0 +: WORD_W] = w0;
    req_valid = 4'b0011;
    #1;
    chk("rst_ready_held", req_ready, 0);
    reset = 1'b0;
    #1;
    chk("rel_ready", req_ready, 1 << model_grant(req_valid, m_last));
    #1;
    clk_en = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    m_last = 0;
    collect("rel", 0, w0);
    @(posedge clk); #1;

    // Single requests
    serve("ones", 2, 32'hFFFFFFFF);
    serve("zero", 2, 32'h00000000);
    serve("ends", 2, 32'h80000001);
    serve("a5", 2, 32'hA5A5A5A5);
    for (int i = 0; i < 6; i++) serve("rand", $urandom_range(0, NREQ - 1), $urandom);

    // Fairness with all requesters continuously valid
    for (int i = 0; i < NREQ; i++) begin
      fw[i] = $urandom;
      req_data[i*WORD_W +: WORD_W] = fw[i];
    end
    req_valid = '1; res_ready = 1'b1;
    #1;
    nh = 0; nr = 0; prev = -1; stop = 1'b0;
    for (int c = 0; c < 80 && nr < 5; c++) begin
      if (stop) req_valid = '0;
      if (req_ready != 0) begin
        g = model_grant(req_valid, m_last);
        chk("rr_grant", req_ready, 1 << g);
        if (prev >= 0) chk("rr_gap", c - prev, 6);
        prev = c; m_last = g; pend.push_back(g); nh++;
        if (nh == 5) stop = 1'b1;
      end
      if (res_valid) begin
        if (pend.size() == 0) chk("rr_unexpected", res_valid, 0);
        else begin
          g = pend.pop_front();
          chk("rr_id", res_id, g);
          chk("rr_cnt", res_count, $countones(fw[g]));
        end
        nr++;
      end
      @(posedge clk); #1;
    end
    chk("rr_results", nr, 5);
    req_valid = '0;
    @(posedge clk); #1;

    // Backpressure in DONE
    bw = $urandom;
    req_data[1*WORD_W +: WORD_W] = bw;
    req_valid = 4'b0010; res_ready = 1'b0;
    await_grant("bp", g);
    @(posedge clk); #1;
    req_valid = '1;
    m_last = g;
    collect("bp", g, bw);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_cnt", res_count, $countones(bw));
      chk("bp_id", res_id, g);
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    res_ready = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    chk("bp_release", {res_valid, busy}, 2'b00);

    // Reset during COUNT
    rw = 32'hFFFF0000 | $urandom_range(1, 255);
    req_data[1*WORD_W +: WORD_W] = rw;
    req_valid = 4'b0010;
    await_grant("mid", g);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst", {res_valid, busy}, 2'b00);
    reset = 1'b0;
    m_last = NREQ - 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mid_novalid", res_valid, 0);
    end
    rw = $urandom;
    req_data[1*WORD_W +: WORD_W] = rw;
    req_data[3*WORD_W +: WORD_W] = ~rw;
    req_valid = 4'b1010;
    await_grant("mid_after", g);
    @(posedge clk); #1;
    req_valid = '0;
    m_last = g;
    collect("mid_after", g, (g == 3) ? ~rw : rw);
    @(posedge clk); #1;

    // Withdrawal while in DONE
    ww = $urandom; w3 = $urandom;
    req_data[2*WORD_W +: WORD_W] = ww;
    req_valid = 4'b0100; res_ready = 1'b0;
    await_grant("wd_pre", g);
    @(posedge clk); #1;
    req_valid = '0;
    m_last = g;
    collect("wd_pre", g, ww);
    req_data[3*WORD_W +: WORD_W] = w3;
    req_valid = 4'b1001;
    #1;
    chk("wd_done_ready", req_ready, 0);
    seen0 = req_ready[0];
    @(posedge clk); #1;
    req_valid = 4'b1000; res_ready = 1'b1;
    #1;
    seen0 |= req_ready[0];
    @(posedge clk); #1;
    seen0 |= req_ready[0];
    await_grant("wd", g);
    seen0 |= req_ready[0];
    chk("wd_never0", seen0, 0);
    @(posedge clk); #1;
    req_valid = '0;
    m_last = g;
    collect("wd", 3, w3);
    @(posedge clk); #1;
    req_valid = '1;
    await_grant("wd_last", g);
    @(posedge clk); #1;
    req_valid = '0;
    m_last = g;
    collect("wd_last", g, req_data[g*WORD_W +: WORD_W]);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
